seq_slice_adder: RTL and testbench

SEQ_SLICE_ADDER -- requirements
Module: seq_slice_adder

---
 rtl/seq_slice_adder.sv | 106 ++++++++++
 tb/tb_seq_slice_adder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_slice_adder.sv
// Multi-cycle adder/subtractor: one SLICE-bit chunk per clock, LSB slice first,
// with a ready/valid handshake on the operand side and on the result side.
module seq_slice_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("seq_slice_adder: WIDTH must be at least 2");
        end
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("seq_slice_adder: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   slice_sum;
    logic             slice_ovf;

    always_comb begin
        a_sl      = a_q[cnt*SLICE +: SLICE];
        b_sl      = b_q[cnt*SLICE +: SLICE];
        slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
        // carry into the MSB is recovered as a ^ b ^ sum at that bit position
        slice_ovf = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ slice_sum[SLICE-1] ^ slice_sum[SLICE];
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= X;
                        b_q   <= Sub ? ~Y : Y;
                        carry <= Sub | Cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    S[cnt*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
                    carry                 <= slice_sum[SLICE];
                    if (cnt == LAST) begin
                        Cout  <= slice_sum[SLICE];
                        Ovf   <= slice_ovf;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_slice_adder.sv
// Directed bench for seq_slice_adder: a 32/8 instance for the main cases and an
// 8/8 instance for the single-slice case, sharing clock, reset and handshakes.
module tb_seq_slice_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] x = '0, y = '0;
    logic        cin = 1'b0, sub = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        use8 = 1'b0;

    logic        iv32, iv8, ir32, ir8, ov32, ov8, c32, c8, o32, o8;
    logic [31:0] s32;
    logic [7:0]  s8;

    logic        o_ready, o_valid, o_cout, o_ovf;
    logic [31:0] o_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign iv32    = in_valid & ~use8;
    assign iv8     = in_valid & use8;
    assign o_ready = use8 ? ir8 : ir32;
    assign o_valid = use8 ? ov8 : ov32;
    assign o_cout  = use8 ? c8 : c32;
    assign o_ovf   = use8 ? o8 : o32;
    assign o_s     = use8 ? {24'h0, s8} : s32;

    seq_slice_adder #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk(clk), .rst(rst), .X(x), .Y(y), .Cin(cin), .Sub(sub),
        .in_valid(iv32), .in_ready(ir32), .S(s32), .Cout(c32), .Ovf(o32),
        .out_valid(ov32), .out_ready(out_ready)
    );

    seq_slice_adder #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst(rst), .X(x[7:0]), .Y(y[7:0]), .Cin(cin), .Sub(sub),
        .in_valid(iv8), .in_ready(ir8), .S(s8), .Cout(c8), .Ovf(o8),
        .out_valid(ov8), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation, check handshake, latency and result; optionally hold
    // the result for a few cycles while garbage is offered on the input side.
    task automatic op(input string tag, input logic [31:0] xa, input logic [31:0] yb,
                      input logic ci, input logic sb, input logic [31:0] exp_s,
                      input logic exp_c, input logic exp_o, input int exp_lat,
                      input int hold);
        int n;
        @(negedge clk);
        chk({tag, " in_ready idle"}, {31'h0, o_ready}, 32'h1);
        x = xa; y = yb; cin = ci; sub = sb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        x = $urandom; y = $urandom; cin = ~ci; sub = ~sb;
        n = 0;
        while (!o_valid && n < 20) begin
            chk({tag, " in_ready busy"}, {31'h0, o_ready}, 32'h0);
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " out_valid"}, {31'h0, o_valid}, 32'h1);
        chk({tag, " S"}, o_s, exp_s);
        chk({tag, " Cout"}, {31'h0, o_cout}, {31'h0, exp_c});
        chk({tag, " Ovf"}, {31'h0, o_ovf}, {31'h0, exp_o});
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid; x = $urandom; y = $urandom;
            @(negedge clk);
            chk({tag, " hold S"}, o_s, exp_s);
            chk({tag, " hold Cout/Ovf"}, {30'h0, o_cout, o_ovf}, {30'h0, exp_c, exp_o});
            chk({tag, " hold in_ready"}, {31'h0, o_ready}, 32'h0);
            chk({tag, " hold out_valid"}, {31'h0, o_valid}, 32'h1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " release in_ready"}, {31'h0, o_ready}, 32'h1);
        chk({tag, " release out_valid"}, {31'h0, o_valid}, 32'h0);
    endtask

    initial begin
        logic seen_valid;
        #2;
        chk("reset in_ready", {31'h0, o_ready}, 32'h1);
        chk("reset out_valid", {31'h0, o_valid}, 32'h0);
        chk("reset S", o_s, 32'h0);
        chk("reset Cout/Ovf", {30'h0, o_cout, o_ovf}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4, 0);
        op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4, 0);
        op("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 4, 0);
        op("add_cin",   32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0, 4, 0);
        op("add_chain", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 4, 0);
        op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 4, 0);
        op("sub_eq",    32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 4, 0);
        op("hold",      32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4, 3);

        // Abort mid-operation: reset lands after the second RUN edge.
        @(negedge clk);
        x = 32'h1111_1111; y = 32'h2222_2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort partial S", o_s[15:0], 32'h3333);
        #2 rst = 1'b1;
        #1;
        chk("abort in_ready", {31'h0, o_ready}, 32'h1);
        chk("abort out_valid", {31'h0, o_valid}, 32'h0);
        chk("abort S", o_s, 32'h0);
        chk("abort Cout/Ovf", {30'h0, o_cout, o_ovf}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_valid) seen_valid = 1'b1;
        end
        chk("abort no out_valid", {31'h0, seen_valid}, 32'h0);
        op("after_abort", 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0301, 1'b0, 1'b0, 4, 0);

        use8 = 1'b1;
        op("w8_wrap", 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1, 0);
        op("w8_ovf",  32'h0000_007F, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
